riscv_mem_arbiter: RTL and testbench
====================================

# riscv_mem_arbiter

Shares one unified memory port between the instruction-fetch requester (IF stage) and the data requester (MEM stage) of the 5-stage pipelined core. It runs a single-outstanding-transaction FSM toward memory, picks a winner when both stages request, and raises per-requester stall flags that feed the hazard unit. A data-over-fetch priority rule is used, with an optional starvation guard.

## Interface
Parameters:
- XLEN, 32, data/address width
- STARVE_LIMIT, 4, consecutive data grants with a fetch pending before fetch is forced to win (≥1)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_rvalid or if_flush
- if_addr  in  XLEN  fetch address
- if_flush  in  1  branch redirect; discard the in-flight fetch response
- if_rdata  out  XLEN  fetch data, valid with if_rvalid
- if_rvalid  out  1  one-cycle fetch completion pulse
- if_stall  out  1  fetch pending, not completed this cycle
- d_req  in  1  data request; held until d_rvalid
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data address
- d_wdata  in  XLEN  store data
- d_be  in  XLEN/8  byte enables
- d_rdata  out  XLEN  load data, valid with d_rvalid
- d_rvalid  out  1  one-cycle data completion pulse (load and store)
- d_stall  out  1  data pending, not completed this cycle
- mem_req  out  1  memory command valid
- mem_we, mem_addr, mem_wdata, mem_be  out  1/XLEN/XLEN/XLEN/8  latched command
- mem_ready  in  1  memory accepts command when mem_req & mem_ready
- mem_rvalid  in  1  response/ack; at least one cycle after acceptance
- mem_rdata  in  XLEN  response data

## Operation
- FSM states are IDLE, REQ and WAIT. Owner register is IF or D. Drop flag and streak counter are also kept.
- IDLE: if any request is present, select the winner, latch its command into the mem_* registers and go to REQ. With no request, stay in IDLE.
- Winner rule: D wins over IF, except under the starvation guard (see Configuration).
- Fetch commands: mem_we=0, mem_be=all ones, mem_wdata=0.
- REQ: mem_req=1 and the command is held stable. On mem_ready, go to WAIT. While mem_ready stays low, remain in REQ.
- WAIT: on mem_rvalid, return to IDLE and drive the owner's rdata and rvalid combinationally from mem_rdata and mem_rvalid.
- if_flush while IF owns REQ or WAIT: set the drop flag. The transaction still completes, but the response is swallowed (if_rvalid stays 0). The drop flag clears on return to IDLE.
- if_flush while in IDLE or while D owns the port: no effect.
- mem_rvalid outside WAIT is ignored.
- if_stall = if_req & ~if_rvalid. d_stall = d_req & ~d_rvalid. Both are combinational.
- Reset: state IDLE, owner IF, drop 0, streak 0, mem_req 0, all mem_* registers 0, all rvalid and rdata outputs 0.
- Reset mid-transaction abandons the transaction. A late mem_rvalid after reset is ignored because the FSM is in IDLE.

## Timing
- Request seen in IDLE at cycle T: mem_req rises at T+1.
- If mem_ready is asserted at T+1, the response can arrive at T+2 at the earliest. The owner's rvalid appears in the same cycle as mem_rvalid.
- The FSM is back in IDLE at T+3, so minimum turnaround is 3 cycles per transaction.
- Each wait cycle on mem_ready or mem_rvalid adds exactly one cycle.
- Requests arriving while the FSM is not in IDLE are evaluated at the next IDLE cycle.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - streak increments on each D grant made while if_req=1, and clears on any IF grant.
  - When streak == STARVE_LIMIT and both requests are present, IF wins.
  - streak saturates at STARVE_LIMIT.
- ARB_STARVE_GUARD_EN undefined: strict D priority, streak logic is absent, and IF can be starved indefinitely.

## Test plan
- Fetch only:
  - Stimulus: if_req, if_addr=0x100 at T; mem_ready=1 at T+1; mem_rvalid with mem_rdata=0x00000013 at T+2.
  - Response: mem_addr=0x100 at T+1; if_rvalid=1 and if_rdata=0x13 at T+2; if_stall=1 at T and T+1, 0 at T+2.
- Simultaneous requests:
  - Stimulus: if_req (0x200) and d_req load (0x1000) at T.
  - Response: first mem command is 0x1000 with mem_we=0. After d_rvalid, the next command is 0x200.
- Store and backpressure:
  - Stimulus: d_we=1, d_addr=0x2004, d_wdata=0xDEADBEEF, d_be=0011; mem_ready held low 5 cycles.
  - Response: command stable for all 5 cycles; accepted on the 6th; d_rvalid pulses once on ack.
- Starvation:
  - Stimulus: d_req held continuously and if_req pending, STARVE_LIMIT=4.
  - Response with the macro: 4 D grants, then 1 IF grant. Without the macro: no IF grant until d_req drops.
- Flush:
  - Stimulus: if_flush during WAIT for fetch 0x300, then a new fetch to 0x400.
  - Response: no if_rvalid for 0x300; FSM returns to IDLE; 0x400 is served normally.
- Reset:
  - Stimulus: reset asserted in WAIT; mem_rvalid arrives one cycle after reset deasserts.
  - Response: all outputs 0 on the next cycle; no rvalid pulse for the late response; FSM stays in IDLE.

Source files
------------

// File: rtl/riscv_mem_arbiter.sv
// rtl/riscv_mem_arbiter.sv - unified memory port arbiter for the IF and MEM stages
//
// Purpose:
//   Shares a single memory port between instruction fetch (IF) and data
//   access (D). Only one transaction is outstanding at a time: IDLE picks a
//   winner and latches its command, REQ presents it until mem_ready, and WAIT
//   waits for mem_rvalid. The response is routed combinationally to the owner.
//   D normally wins when both stages request.
//
// Optional feature:
//   ARB_STARVE_GUARD_EN - when defined, a saturating streak counter counts D
//   grants made while a fetch was pending; once it reaches STARVE_LIMIT the
//   next contested grant goes to IF. When undefined, D has strict priority.
//
// Ports:
//   clk, reset                         clock, synchronous active-high reset
//   if_req/if_addr/if_flush            fetch request, address, redirect
//   if_rdata/if_rvalid/if_stall        fetch response and stall flag
//   d_req/d_we/d_addr/d_wdata/d_be     data request and command
//   d_rdata/d_rvalid/d_stall           data response and stall flag
//   mem_req/mem_we/mem_addr/
//   mem_wdata/mem_be                   registered memory command
//   mem_ready                          command accepted when mem_req & mem_ready
//   mem_rvalid/mem_rdata               memory response
module riscv_mem_arbiter #(
  parameter int XLEN         = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [XLEN-1:0]   if_addr,
  input  logic              if_flush,
  output logic [XLEN-1:0]   if_rdata,
  output logic              if_rvalid,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [XLEN-1:0]   d_addr,
  input  logic [XLEN-1:0]   d_wdata,
  input  logic [XLEN/8-1:0] d_be,
  output logic [XLEN-1:0]   d_rdata,
  output logic              d_rvalid,
  output logic              d_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [XLEN-1:0]   mem_addr,
  output logic [XLEN-1:0]   mem_wdata,
  output logic [XLEN/8-1:0] mem_be,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int BEW = XLEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_e;

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  logic              drop_q, drop_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BEW-1:0]    mem_be_q, mem_be_d;

  logic              grant_if;
  logic              grant_d;
  logic              pick_d;
  logic              starve_force;
  logic              resp_fire;

`ifdef ARB_STARVE_GUARD_EN
  localparam int SW = (STARVE_LIMIT < 2) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  logic [SW-1:0] streak_q, streak_d;

  // IF is forced to win only when it actually competes with D.
  assign starve_force = if_req && (streak_q == STREAK_MAX);

  always_comb begin
    streak_d = streak_q;
    if (grant_if) begin
      streak_d = '0;
    end else if (grant_d && if_req && (streak_q != STREAK_MAX)) begin
      streak_d = streak_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`else
  assign starve_force = 1'b0;
`endif

  // With d_req low this is 0, so IF takes the port whenever it alone requests.
  assign pick_d    = d_req && !starve_force;

  assign resp_fire = (state_q == S_WAIT) && mem_rvalid;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    drop_d      = drop_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    grant_if    = 1'b0;
    grant_d     = 1'b0;

    case (state_q)
      S_IDLE: begin
        drop_d = 1'b0;
        if (d_req || if_req) begin
          state_d   = S_REQ;
          mem_req_d = 1'b1;
          if (pick_d) begin
            grant_d     = 1'b1;
            owner_d     = OWN_D;
            mem_we_d    = d_we;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
            mem_be_d    = d_be;
          end else begin
            grant_if    = 1'b1;
            owner_d     = OWN_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr;
            mem_wdata_d = '0;
            mem_be_d    = '1;
          end
        end
      end

      S_REQ: begin
        if (mem_ready) begin
          state_d   = S_WAIT;
          mem_req_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (mem_rvalid) begin
          state_d = S_IDLE;
          drop_d  = 1'b0;
        end
      end

      default: begin
        state_d   = S_IDLE;
        mem_req_d = 1'b0;
        drop_d    = 1'b0;
      end
    endcase

    // A redirect while our fetch is in flight poisons its response. When the
    // response lands in the same cycle the flag is not needed: the pulse is
    // masked directly below and the FSM is leaving WAIT anyway.
    if (if_flush && (owner_q == OWN_IF) && (state_q != S_IDLE) && !resp_fire) begin
      drop_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_IF;
      drop_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      drop_q      <= drop_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

  // Responses are only honoured in WAIT, so stray or post-reset mem_rvalid
  // pulses never reach either requester.
  assign d_rvalid  = resp_fire && (owner_q == OWN_D);
  assign d_rdata   = d_rvalid ? mem_rdata : '0;
  assign if_rvalid = resp_fire && (owner_q == OWN_IF) && !drop_q && !if_flush;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;

  assign if_stall  = if_req && !if_rvalid;
  assign d_stall   = d_req && !d_rvalid;

endmodule

// File: tb/tb_riscv_mem_arbiter.sv
// tb/tb_riscv_mem_arbiter.sv - randomized scoreboard bench for riscv_mem_arbiter
module tb_riscv_mem_arbiter;

  localparam int XLEN  = 32;
  localparam int LIMIT = 4;
`ifdef ARB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req, if_flush, if_rvalid, if_stall;
  logic [XLEN-1:0] if_addr, if_rdata;
  logic            d_req, d_we, d_rvalid, d_stall;
  logic [XLEN-1:0] d_addr, d_wdata, d_rdata;
  logic [3:0]      d_be;
  logic            mem_req, mem_we, mem_ready, mem_rvalid;
  logic [XLEN-1:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]      mem_be;

  riscv_mem_arbiter #(.XLEN(XLEN), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_rdata(if_rdata), .if_rvalid(if_rvalid), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_rvalid(d_rvalid), .d_stall(d_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  be;
    int          acc;
  } cmd_t;

  typedef struct {
    bit          is_if;
    logic [31:0] data;
    int          cyc;
  } rsp_t;

  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  bit mon_en = 1'b0;
  bit exp_mem_req = 1'b0;

  // Transaction-level model: a grant at cycle t_g owns the port until t_r,
  // the port is free again at t_r + 1.
  bit          busy = 1'b0;
  int          t_g, t_a, t_r;
  bit          cur_is_if, cur_drop;
  logic [31:0] cur_rdata;
  int          streak = 0;
  bit          if_act = 1'b0, d_act = 1'b0;
  logic [31:0] if_a;
  logic        dw;
  logic [31:0] da, dwd;
  logic [3:0]  dbe;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int if_p, input int d_p, input bit fl_en);
    bit pick_d;
    int w;
    cmd_t c;
    rsp_t r;

    if (busy && cyc > t_r) begin
      if (!cur_is_if) d_act = 1'b0;
      else if (!cur_drop) if_act = 1'b0;
      busy = 1'b0;
    end

    if_flush = 1'b0;
    if (fl_en) begin
      if (busy && cur_is_if && cyc > t_g && cyc < t_r && !cur_drop) begin
        if ($urandom_range(0, 7) == 0) begin
          if_flush = 1'b1;
          cur_drop = 1'b1;
          if_act   = 1'b0;
        end
      end else if (!(busy && cur_is_if) && $urandom_range(0, 23) == 0) begin
        if_flush = 1'b1;
        if_act   = 1'b0;
      end
    end

    if (!if_act && !if_flush && $urandom_range(0, 99) < if_p) begin
      if_act = 1'b1;
      if_a   = $urandom() & 32'hFFFF_FFFC;
    end
    if (!d_act && $urandom_range(0, 99) < d_p) begin
      d_act = 1'b1;
      dw    = 1'($urandom());
      da    = $urandom();
      dwd   = $urandom();
      dbe   = 4'($urandom());
    end
    if_req  = if_act;
    if_addr = if_act ? if_a : $urandom();
    d_req   = d_act;
    d_we    = d_act ? dw  : 1'($urandom());
    d_addr  = d_act ? da  : $urandom();
    d_wdata = d_act ? dwd : $urandom();
    d_be    = d_act ? dbe : 4'($urandom());

    if (!busy && (if_req || d_req)) begin
      pick_d = d_req && !(GUARD && if_req && streak == LIMIT);
      if (pick_d) begin
        if (if_req && streak < LIMIT) streak++;
        c.addr = da; c.wdata = dwd; c.we = dw; c.be = dbe;
      end else begin
        streak = 0;
        c.addr = if_a; c.wdata = 32'h0; c.we = 1'b0; c.be = 4'hF;
      end
      w = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0;
      busy      = 1'b1;
      cur_is_if = !pick_d;
      cur_drop  = 1'b0;
      cur_rdata = $urandom();
      t_g = cyc;
      t_a = cyc + 1 + w;
      t_r = t_a + $urandom_range(1, 3);
      c.acc = t_a;
      cmd_q.push_back(c);
    end

    if (busy && cyc > t_g && cyc < t_a) mem_ready = 1'b0;
    else if (busy && cyc == t_a)        mem_ready = 1'b1;
    else                                mem_ready = 1'($urandom());

    mem_rdata = $urandom();
    if (busy && cyc == t_r) begin
      mem_rvalid = 1'b1;
      mem_rdata  = cur_rdata;
      if (!cur_is_if || !cur_drop) begin
        r.is_if = cur_is_if; r.data = cur_rdata; r.cyc = cyc;
        rsp_q.push_back(r);
      end
    end else if (busy && cyc > t_a && cyc < t_r) begin
      mem_rvalid = 1'b0;
    end else begin
      mem_rvalid = ($urandom_range(0, 4) == 0);
    end

    exp_mem_req = busy && cyc > t_g && cyc <= t_a;
  endtask

  always @(negedge clk) begin
    bit exp_if, exp_d;
    if (mon_en) begin
      chk("mem_req", mem_req, exp_mem_req);
      if (mem_req && cmd_q.size() > 0) begin
        chk("mem_addr", mem_addr, cmd_q[0].addr);
        chk("mem_wdata", mem_wdata, cmd_q[0].wdata);
        chk("mem_we_be", {mem_we, mem_be}, {cmd_q[0].we, cmd_q[0].be});
        if (mem_ready) begin
          chk("accept_cycle", cyc, cmd_q[0].acc);
          void'(cmd_q.pop_front());
        end
      end

      exp_if = 1'b0;
      exp_d  = 1'b0;
      if (rsp_q.size() > 0 && rsp_q[0].cyc <= cyc) begin
        chk("rsp_cycle", cyc, rsp_q[0].cyc);
        exp_if = rsp_q[0].is_if;
        exp_d  = !rsp_q[0].is_if;
      end
      chk("if_rvalid", if_rvalid, exp_if);
      chk("d_rvalid", d_rvalid, exp_d);
      chk("if_stall", if_stall, if_req && !exp_if);
      chk("d_stall", d_stall, d_req && !exp_d);
      if (exp_if || exp_d) begin
        if (if_rvalid || d_rvalid)
          chk("rdata", if_rvalid ? if_rdata : d_rdata, rsp_q[0].data);
        void'(rsp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 1'b0);
    chk({tag, "_mem_addr"}, mem_addr, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'h0);
    chk({tag, "_mem_we_be"}, {mem_we, mem_be}, 5'h0);
    chk({tag, "_rvalids"}, {if_rvalid, d_rvalid}, 2'b00);
    chk({tag, "_if_rdata"}, if_rdata, 32'h0);
    chk({tag, "_d_rdata"}, d_rdata, 32'h0);
  endtask

  initial begin
    int n;
    reset = 1'b1;
    if_req = 0; if_addr = 0; if_flush = 0;
    d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_be = 0;
    mem_ready = 0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) tick();
    check_idle_outputs("reset");
    reset = 1'b0;
    mem_rvalid = 1'b0;
    tick();

    mon_en = 1'b1;
    for (int i = 0; i < 1500; i++) begin tick(); step(30, 30, 1'b1); end
    for (int i = 0; i < 300; i++)  begin tick(); step(100, 100, 1'b0); end
    for (int i = 0; i < 1000; i++) begin tick(); step(70, 50, 1'b1); end

    n = 0;
    while ((busy || if_act || d_act) && n < 300) begin
      tick();
      step(0, 0, 1'b0);
      n++;
    end
    chk("drain_bound", n < 300, 1'b1);
    tick(); step(0, 0, 1'b0);
    tick(); step(0, 0, 1'b0);
    mon_en = 1'b0;
    chk("cmd_q_empty", cmd_q.size(), 0);
    chk("rsp_q_empty", rsp_q.size(), 0);

    // Reset while a load sits in WAIT, then a late response.
    if_flush = 0; if_req = 0; mem_ready = 0; mem_rvalid = 0;
    d_req = 1; d_we = 0; d_addr = 32'h1000; d_wdata = 32'h0; d_be = 4'hF;
    tick(); mem_ready = 1'b1;
    #3 chk("rst_pre_mem_req", mem_req, 1'b1);
    chk("rst_pre_mem_addr", mem_addr, 32'h1000);
    tick(); mem_ready = 1'b0; reset = 1'b1;
    tick(); reset = 1'b0; d_req = 0; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    #3 check_idle_outputs("post_reset");
    tick();
    #3 chk("late_rvalid_ignored", {if_rvalid, d_rvalid, mem_req}, 3'b000);

    // FSM must still be idle: a fresh fetch follows the normal 3-cycle path.
    tick(); mem_rvalid = 1'b0; if_req = 1'b1; if_addr = 32'h400;
    #3 chk("fetch_stall_T", {if_stall, mem_req}, 2'b10);
    tick(); mem_ready = 1'b1;
    #3 chk("fetch_mem_req_T1", mem_req, 1'b1);
    chk("fetch_addr_T1", mem_addr, 32'h400);
    chk("fetch_we_be_T1", {mem_we, mem_be}, 5'h0F);
    tick(); mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h0000_0013;
    #3 chk("fetch_rvalid_T2", {if_rvalid, if_stall}, 2'b10);
    chk("fetch_rdata_T2", if_rdata, 32'h13);
    tick(); if_req = 1'b0; mem_rvalid = 1'b0;
    #3 chk("fetch_done_T3", {mem_req, if_rvalid}, 2'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
